vpu_writeback: RTL and testbench
================================

# vpu_writeback

Downstream stage of the VPU. It takes the two 32-bit activation outputs per row and requantizes each to int8 with a scale, a rounding right shift, a zero point and saturation. It packs both columns into one 16-bit word, buffers the words in a small FIFO, and writes them to sequential unified-buffer (UB) addresses under a start/done command. The VPU cannot stall, so the FIFO absorbs UB back-pressure, and any data that arrives while the FIFO is full is flagged.

## Interface
Parameters:
- FIFO_DEPTH, 8: packed-word FIFO entries; must be a power of 2, at least 2.
- ADDR_WIDTH, 8: UB address width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- valid_in  in  1  data_in0/1 valid this cycle (the VPU's valid_out).
- data_in0  in  32  signed column-0 activation.
- data_in1  in  32  signed column-1 activation.
- scale  in  16  unsigned multiplier; must be held stable while busy.
- shift  in  5  right-shift amount, 0..31; must be held stable while busy.
- zero_point  in  8  signed output offset; must be held stable while busy.
- start  in  1  command pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first UB address, latched on start.
- row_count  in  ADDR_WIDTH  number of words to write, latched on start.
- ub_wr_ready  in  1  UB accepts a write this cycle.
- ub_wr_en  out  1  write request.
- ub_wr_addr  out  ADDR_WIDTH  write address.
- ub_wr_data  out  16  {col1_int8, col0_int8}; col0 is in bits [7:0].
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a command completes.
- overflow  out  1  sticky; set when a word is lost. Cleared only by reset.

## Operation
Datapath, identical for each column:
- S1 (registered): p = data_in × zero-extended scale, as a 49-bit signed product.
- S2 (registered):
  - Rounding: if shift > 0, r = (p + (1 << (shift−1))) >>> shift; otherwise r = p. This is round-half-up toward +inf.
  - Zero point: q = r + sign-extended zero_point.
  - Saturation: q is clamped to [−128, 127].
- A valid S2 word is pushed into the FIFO.

FIFO:
- A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Otherwise the word is dropped and overflow is set.
- The pipeline and FIFO accept data in every state, including IDLE. Words that arrive before start are written once RUN begins.

State machine:
- IDLE → RUN on start with row_count ≠ 0. This latches ptr = base_addr and remaining = row_count.
- IDLE → DONE on start with row_count = 0. No write is made.
- RUN: ub_wr_en = FIFO not empty. ub_wr_addr = ptr. ub_wr_data = FIFO head.
  - A write completes (pop) on a cycle where ub_wr_en && ub_wr_ready.
  - On each completed write: ptr increments and wraps modulo 2^ADDR_WIDTH, and remaining decrements.
  - The write that brings remaining from 1 to 0 moves the state to DONE.
- DONE: done = 1 for one cycle, then the state returns to IDLE.
- start is ignored in RUN and DONE.
- Outside RUN: ub_wr_en = 0 and the FIFO is not popped.
- ub_wr_data = 0 whenever the FIFO is empty.
- Words beyond row_count stay in the FIFO for the next command.

## Timing
- Reset values: ub_wr_en, ub_wr_addr, ub_wr_data, busy, done and overflow are all 0. The state is IDLE, the FIFO and S1/S2 valids are cleared, and ptr and remaining are 0.
- Reset mid-operation discards all buffered and in-flight data.
- Latency: valid_in high in cycle t with the FIFO empty and the state RUN gives ub_wr_en high in cycle t+3, with ub_wr_data combinational from the FIFO head.
- Throughput: one word per cycle sustained while ub_wr_ready = 1.
- ub_wr_en, ub_wr_addr and ub_wr_data are held stable while ub_wr_ready = 0.
- busy rises the cycle after start is sampled and falls in the DONE cycle.
- done is high exactly one cycle after the final completed write, or one cycle after a start with row_count = 0.

## Test plan
- Basic requantize: scale = 256, shift = 8, zp = 0, start(base 0x10, count 3), rows (100, −5), (200, −300), (0, 127), ub_wr_ready = 1. Required: writes 0x10 = {−5, 100}, 0x11 = {−128, 127}, 0x12 = {127, 0}; first ub_wr_en 3 cycles after the first valid_in; done one cycle after the write to 0x12.
- Rounding and zero point: scale = 128, shift = 8, zp = 0.
  - Inputs 3 and −3 give 2 and −1.
  - With zp = 5, scale = 256, shift = 8: input 10 gives 15.
  - With shift = 0, scale = 1: input 7 gives 7.
- Back-pressure: ub_wr_ready = 0 for 5 cycles with 4 rows in flight. Required: no loss, no overflow, outputs stable while stalled, words drained in order at consecutive addresses.
- Overflow: FIFO_DEPTH = 8, ub_wr_ready = 0, 11 consecutive valid rows. Required: 8 words are retained (S2 is not stalled), overflow = 1 and remains 1 after the drain.
- Edge commands:
  - row_count = 0 gives done the next cycle and no write.
  - base = 0xFE, count = 3 writes 0xFE, 0xFF, 0x00.
  - start during RUN is ignored.
  - Data arriving in IDLE is written after a later start.
- Reset mid-RUN: after 2 of 5 writes, assert reset. Required: all outputs 0 the next cycle, FIFO empty, and a new command writes only newly supplied data.

Source files
------------

// File: rtl/vpu_writeback.sv
// ----------------------------------------------------------------------------
// vpu_writeback: requantizes two int32 activations to int8, packs them, buffers
// them in a FIFO and writes them to sequential UB addresses.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vpu_writeback #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [31:0]           data_in0,
  input  logic [31:0]           data_in1,
  input  logic [15:0]           scale,
  input  logic [4:0]            shift,
  input  logic [7:0]            zero_point,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] row_count,
  input  logic                  ub_wr_ready,
  output logic                  ub_wr_en,
  output logic [ADDR_WIDTH-1:0] ub_wr_addr,
  output logic [15:0]           ub_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]      c_ptr_one  = 1;
  localparam logic [ADDR_WIDTH-1:0] c_addr_one = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Round-half-up shift, add zero point, clamp to int8.  The 49-bit product
  // never exceeds 2^47 in magnitude, so none of the sums below can wrap.
  function automatic logic [7:0] f_requant(input logic signed [48:0] p,
                                           input logic [4:0] sh,
                                           input logic [7:0] zp);
    logic signed [48:0] rnd;
    logic signed [48:0] sum;
    logic signed [48:0] r;
    logic signed [48:0] q;
    rnd = (sh == 5'd0) ? 49'sd0 : (49'sd1 <<< (sh - 5'd1));
    sum = p + rnd;
    r   = sum >>> sh;
    q   = r + $signed({{41{zp[7]}}, zp});
    if (q > 49'sd127)
      return 8'h7F;
    else if (q < -49'sd128)
      return 8'h80;
    else
      return q[7:0];
  endfunction

  logic signed [48:0] w_scale_ext;
  logic signed [48:0] w_p0;
  logic signed [48:0] w_p1;
  logic               r_s1_valid;
  logic signed [48:0] r_p0;
  logic signed [48:0] r_p1;
  logic               r_s2_valid;
  logic [7:0]         r_q0;
  logic [7:0]         r_q1;

  assign w_scale_ext = $signed({33'd0, scale});
  assign w_p0 = $signed({{17{data_in0[31]}}, data_in0}) * w_scale_ext;
  assign w_p1 = $signed({{17{data_in1[31]}}, data_in1}) * w_scale_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_p0       <= '0;
      r_p1       <= '0;
      r_s2_valid <= 1'b0;
      r_q0       <= '0;
      r_q1       <= '0;
    end else begin
      r_s1_valid <= valid_in;
      r_p0       <= w_p0;
      r_p1       <= w_p1;
      r_s2_valid <= r_s1_valid;
      r_q0       <= f_requant(r_p0, shift, zero_point);
      r_q1       <= f_requant(r_p1, shift, zero_point);
    end
  end

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] r_remaining;
  logic [15:0]           r_mem [FIFO_DEPTH];
  logic [PTR_W:0]        r_wptr;
  logic [PTR_W:0]        r_rptr;
  logic                  r_overflow;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_pop   = (r_state == S_RUN) && !w_empty && ub_wr_ready;
  // The VPU cannot stall: a push into a full FIFO survives only if a pop frees a slot.
  assign w_push  = r_s2_valid && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr[PTR_W-1:0]] <= {r_q1, r_q0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + c_ptr_one;
      if (w_pop)
        r_rptr <= r_rptr + c_ptr_one;
      if (r_s2_valid && !w_push)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr       <= base_addr;
            r_remaining <= row_count;
            r_state     <= (row_count != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (w_pop) begin
            r_ptr       <= r_ptr + c_addr_one;
            r_remaining <= r_remaining - c_addr_one;
            if (r_remaining == c_addr_one)
              r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ub_wr_en   = (r_state == S_RUN) && !w_empty;
  assign ub_wr_addr = r_ptr;
  assign ub_wr_data = w_empty ? 16'h0000 : r_mem[r_rptr[PTR_W-1:0]];
  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_vpu_writeback.sv
// ----------------------------------------------------------------------------
// tb_vpu_writeback: directed vectors and command sequences for vpu_writeback.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vpu_writeback;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [31:0] data_in0;
  logic [31:0] data_in1;
  logic [15:0] scale;
  logic [4:0]  shift;
  logic [7:0]  zero_point;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  row_count;
  logic        ub_wr_ready;
  logic        ub_wr_en;
  logic [7:0]  ub_wr_addr;
  logic [15:0] ub_wr_data;
  logic        busy;
  logic        done;
  logic        overflow;

  vpu_writeback #(.FIFO_DEPTH(8), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .data_in0   (data_in0),
    .data_in1   (data_in1),
    .scale      (scale),
    .shift      (shift),
    .zero_point (zero_point),
    .start      (start),
    .base_addr  (base_addr),
    .row_count  (row_count),
    .ub_wr_ready(ub_wr_ready),
    .ub_wr_en   (ub_wr_en),
    .ub_wr_addr (ub_wr_addr),
    .ub_wr_data (ub_wr_data),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [15:0] sc;
    logic [4:0]  sh;
    logic [7:0]  zp;
    logic [15:0] exp_word;
  } vec_t;

  vec_t        vecs[8];
  int          n_vec;
  int          n_err;
  logic [31:0] in0[16];
  logic [31:0] in1[16];
  logic [15:0] exp_words[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg(input logic [15:0] sc, input logic [4:0] sh, input logic [7:0] zp);
    scale = sc;
    shift = sh;
    zero_point = zp;
  endtask

  task automatic cmd(input logic [7:0] b, input logic [7:0] c);
    base_addr = b;
    row_count = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive n rows back to back, then let the last one reach the FIFO.
  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      data_in0 = in0[i];
      data_in1 = in1[i];
      tick();
    end
    valid_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic expect_writes(input int n, input logic [7:0] b, input bit chk_done);
    int waited;
    logic [7:0] a;
    ub_wr_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      waited = 0;
      while (!ub_wr_en && waited < 20) begin
        tick();
        waited++;
      end
      a = b + 8'(k);
      check("wr_en", {31'd0, ub_wr_en}, 32'd1);
      check("wr_addr", {24'd0, ub_wr_addr}, {24'd0, a});
      check("wr_data", {16'd0, ub_wr_data}, {16'd0, exp_words[k]});
      tick();
    end
    ub_wr_ready = 1'b0;
    if (chk_done) begin
      check("done_after_last", {31'd0, done}, 32'd1);
      check("busy_in_done", {31'd0, busy}, 32'd0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    valid_in = 1'b0;
    data_in0 = '0;
    data_in1 = '0;
    start = 1'b0;
    base_addr = '0;
    row_count = '0;
    ub_wr_ready = 1'b0;
    cfg(16'd256, 5'd8, 8'd0);

    vecs[0] = '{32'd3,          32'hFFFFFFFD, 16'd128,   5'd8,  8'h00, 16'hFF02};
    vecs[1] = '{32'd10,         32'hFFFFFFF6, 16'd256,   5'd8,  8'h05, 16'hFB0F};
    vecs[2] = '{32'd7,          32'hFFFFFF80, 16'd1,     5'd0,  8'h00, 16'h8007};
    vecs[3] = '{32'd100,        32'hFFFFFFFB, 16'd256,   5'd8,  8'h00, 16'hFB64};
    vecs[4] = '{32'h7FFFFFFF,   32'h80000000, 16'd65535, 5'd31, 8'h00, 16'h807F};
    vecs[5] = '{32'd1,          32'hFFFFFFFF, 16'd256,   5'd8,  8'h80, 16'h8081};
    vecs[6] = '{32'd0,          32'd1,        16'd256,   5'd8,  8'h7F, 16'h7F7F};
    vecs[7] = '{32'd1,          32'hFFFFFFFF, 16'd1,     5'd1,  8'h00, 16'h0001};

    tick();
    tick();
    check("rst_wr_en", {31'd0, ub_wr_en}, 32'd0);
    check("rst_wr_addr", {24'd0, ub_wr_addr}, 32'd0);
    check("rst_wr_data", {16'd0, ub_wr_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic requantize with exact latency.
    ub_wr_ready = 1'b1;
    cmd(8'h10, 8'd3);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    valid_in = 1'b1; data_in0 = 32'd100; data_in1 = 32'hFFFFFFFB;
    tick();
    data_in0 = 32'd200; data_in1 = 32'hFFFFFED4;
    tick();
    check("lat_en_t2", {31'd0, ub_wr_en}, 32'd0);
    data_in0 = 32'd0; data_in1 = 32'd127;
    tick();
    valid_in = 1'b0;
    check("lat_en_t3", {31'd0, ub_wr_en}, 32'd1);
    check("basic_addr0", {24'd0, ub_wr_addr}, 32'h10);
    check("basic_data0", {16'd0, ub_wr_data}, 32'hFB64);
    tick();
    check("basic_addr1", {24'd0, ub_wr_addr}, 32'h11);
    check("basic_data1", {16'd0, ub_wr_data}, 32'h807F);
    tick();
    check("basic_en2", {31'd0, ub_wr_en}, 32'd1);
    check("basic_addr2", {24'd0, ub_wr_addr}, 32'h12);
    check("basic_data2", {16'd0, ub_wr_data}, 32'h7F00);
    tick();
    check("basic_done", {31'd0, done}, 32'd1);
    check("basic_busy_low", {31'd0, busy}, 32'd0);
    check("basic_en_low", {31'd0, ub_wr_en}, 32'd0);
    tick();
    check("basic_done_pulse", {31'd0, done}, 32'd0);
    ub_wr_ready = 1'b0;

    // Requantization table, one single-word command per vector.
    for (int i = 0; i < 8; i++) begin
      cfg(vecs[i].sc, vecs[i].sh, vecs[i].zp);
      cmd(8'h40 + 8'(i), 8'd1);
      in0[0] = vecs[i].d0;
      in1[0] = vecs[i].d1;
      exp_words[0] = vecs[i].exp_word;
      feed(1);
      expect_writes(1, 8'h40 + 8'(i), 1'b1);
    end

    // Back-pressure: four words held while the UB stalls.
    cfg(16'd256, 5'd8, 8'd0);
    cmd(8'h20, 8'd4);
    for (int i = 0; i < 4; i++) begin
      in0[i] = 32'(i + 1);
      in1[i] = 32'(-(i + 1));
      exp_words[i] = {8'(-(i + 1)), 8'(i + 1)};
    end
    feed(4);
    for (int s = 0; s < 5; s++) begin
      check("stall_en", {31'd0, ub_wr_en}, 32'd1);
      check("stall_addr", {24'd0, ub_wr_addr}, 32'h20);
      check("stall_data", {16'd0, ub_wr_data}, 32'hFF01);
      tick();
    end
    expect_writes(4, 8'h20, 1'b1);
    check("bp_no_overflow", {31'd0, overflow}, 32'd0);

    // Zero-length command.
    cmd(8'h55, 8'd0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    check("zero_en", {31'd0, ub_wr_en}, 32'd0);
    tick();
    check("zero_done_pulse", {31'd0, done}, 32'd0);

    // Address wrap, with a start during RUN that must be ignored.
    cmd(8'hFE, 8'd3);
    base_addr = 8'h33;
    row_count = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ignore_start_busy", {31'd0, busy}, 32'd1);
    check("ignore_start_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      in0[i] = 32'(20 + i);
      in1[i] = 32'(30 + i);
      exp_words[i] = {8'(30 + i), 8'(20 + i)};
    end
    feed(3);
    expect_writes(3, 8'hFE, 1'b1);

    // Overflow: 11 rows arrive in IDLE with the UB stalled; 8 survive.
    for (int i = 0; i < 11; i++) begin
      in0[i] = 32'(10 + i);
      in1[i] = 32'(i);
      exp_words[i] = {8'(i), 8'(10 + i)};
    end
    feed(11);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    cmd(8'h80, 8'd8);
    expect_writes(8, 8'h80, 1'b1);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("ovf_fifo_drained", {16'd0, ub_wr_data}, 32'd0);

    // Reset in the middle of a five-word command.
    cmd(8'h60, 8'd5);
    for (int i = 0; i < 5; i++) begin
      in0[i] = 32'(40 + i);
      in1[i] = 32'(50 + i);
      exp_words[i] = {8'(50 + i), 8'(40 + i)};
    end
    feed(5);
    expect_writes(2, 8'h60, 1'b0);
    reset = 1'b1;
    tick();
    check("mid_rst_en", {31'd0, ub_wr_en}, 32'd0);
    check("mid_rst_addr", {24'd0, ub_wr_addr}, 32'd0);
    check("mid_rst_data", {16'd0, ub_wr_data}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    tick();
    cmd(8'h70, 8'd2);
    check("post_rst_fifo_empty", {31'd0, ub_wr_en}, 32'd0);
    in0[0] = 32'd60; in1[0] = 32'd61; exp_words[0] = 16'h3D3C;
    in0[1] = 32'd62; in1[1] = 32'd63; exp_words[1] = 16'h3F3E;
    feed(2);
    expect_writes(2, 8'h70, 1'b1);
    check("post_rst_no_extra", {31'd0, ub_wr_en}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
